third_order_conv_bram_writer: RTL and testbench
===============================================

Name: third_order_conv_bram_writer

Overview:
- Write-side stage directly upstream of the third-order convolution BRAM.
- Accepts a stream of signed 8-bit third-order conv results over valid/ready and packs four per 32-bit word, little-endian.
- Drives BRAM port A (byte address, 4-bit byte write-enable), one word per frame position, starting at a base address.
- Signals frame completion so the downstream reader on port B may start.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be 4-aligned.
- FRAME_LEN, 1024, elements per frame; legal range 1..2^20.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame (honoured in IDLE only).
- in_data  input  8  signed conv result.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- BRAM_PORTA_0_clk  output  1  equals clk, passed through combinationally.
- BRAM_PORTA_0_addr  output  32  byte address of the word being written.
- BRAM_PORTA_0_din  output  32  packed word.
- BRAM_PORTA_0_en  output  1  port enable, high only on write cycles.
- BRAM_PORTA_0_we  output  4  byte write mask; bit i enables din[8i+7:8i].
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset: state IDLE; in_ready, BRAM_PORTA_0_en, we, din, addr, busy and done all 0; counters cleared. Reset mid-frame abandons the frame: no partial word is written, and any write register contents are dropped.
- A transfer occurs when in_valid && in_ready. in_ready is registered and is 1 only in PACK.
- FSM states:
  - IDLE: start -> PACK. Clears lane_idx (2b) and elem_cnt; loads word_addr = BASE_ADDR.
  - PACK: each transfer stores the byte into lane lane_idx of the pack register, increments lane_idx (wraps 3->0) and increments elem_cnt.
    - On a transfer with lane_idx==3, or with elem_cnt==FRAME_LEN-1, the completed word is moved to the write register.
    - Write-register contents: din = packed bytes, with lanes not yet filled = 0; we = mask of filled lanes; addr = word_addr.
    - The next cycle asserts en=1 for exactly one cycle, then word_addr += 4.
    - Packing of the next word continues in parallel, so sustained throughput is 1 byte/cycle with no bubbles.
    - A transfer of element FRAME_LEN-1 -> FLUSH, and in_ready drops the following cycle.
  - FLUSH: the final write (en=1) is on the outputs this cycle -> DONE.
  - DONE: done=1 for one cycle; busy still 1 -> IDLE.
- Latency: the byte accepted at cycle T appears in a BRAM write at T+1. done is asserted at T_last+2.
- Outside write cycles: en=0 and we=0. din and addr hold their last value.
- addr increments modulo 2^32 (wrap-around is legal, not flagged).
- start asserted outside IDLE is ignored. start and rst together: rst wins.
- in_valid while in_ready=0 is ignored; the data is not consumed.
- FRAME_LEN % 4 != 0: the final word has a partial we, i.e. 4'b0001, 4'b0011 or 4'b0111.
- Words written per frame = ceil(FRAME_LEN/4). The final address = BASE_ADDR + 4*(ceil(FRAME_LEN/4)-1).

Optional Feature:
- Macro: THIRD_ORDER_CONV_RELU_EN.
- Defined: in_data with bit7=1 (negative) is replaced by 8'h00 before packing. Latency and handshake are unchanged.
- Undefined: bytes are packed unmodified.

Test Plan:
- FRAME_LEN=8, BASE_ADDR=0x100; bytes 01..08 with in_valid held high -> writes at 0x100 din=0x04030201 we=F and at 0x104 din=0x08070605 we=F, en high exactly 2 cycles, done 2 cycles after the last transfer.
- FRAME_LEN=6; bytes AA,BB,CC,DD,EE,FF -> second write at BASE+4 has din=0x0000FFEE and we=4'b0011.
- FRAME_LEN=1; byte 7F -> a single write with din=0x0000007F, we=4'b0001; busy spans 3 cycles after start (PACK accept, FLUSH, DONE).
- in_valid toggled 1,0,1,0 and start re-pulsed mid-frame -> packing is correct, the second start is ignored, and done pulses once.
- rst asserted after 3 of 4 bytes -> no write occurs and all outputs are 0. A new start then writes its first word at BASE_ADDR with lane 0 first.
- RELU_EN defined, bytes 80,01,FF,7F -> din=0x7F000100. Undefined -> din=0x7FFF0180.

Source files
------------

// File: rtl/third_order_conv_bram_writer.sv
// ============================================================================
// Module   : third_order_conv_bram_writer
// Brief    : Packs signed 8-bit third-order conv results four-per-word
//            (little-endian) and writes them to BRAM port A, one word per
//            frame position starting at BASE_ADDR. Pulses done when the
//            frame has been written so the port-B reader may start.
//            Optional macro THIRD_ORDER_CONV_RELU_EN clamps negative bytes
//            to zero before packing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module third_order_conv_bram_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          FRAME_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        BRAM_PORTA_0_clk,
  output logic [31:0] BRAM_PORTA_0_addr,
  output logic [31:0] BRAM_PORTA_0_din,
  output logic        BRAM_PORTA_0_en,
  output logic [3:0]  BRAM_PORTA_0_we,
  output logic        busy,
  output logic        done
);

  // Index of the final element; 21 bits covers FRAME_LEN up to 2^20.
  localparam logic [20:0] c_LAST_IDX = 21'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_lane_idx;
  logic [20:0] r_elem_cnt;
  logic [31:0] r_word_addr;
  logic [31:0] r_pack;
  logic        r_in_ready;
  logic        r_en;
  logic [3:0]  r_we;
  logic [31:0] r_din;
  logic [31:0] r_addr;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_byte;
  logic        w_xfer;
  logic        w_last;
  logic        w_word_end;
  logic [31:0] w_word;
  logic [3:0]  w_mask;

`ifdef THIRD_ORDER_CONV_RELU_EN
  // Negative results are clamped to zero before they reach the pack register.
  assign w_byte = in_data[7] ? 8'h00 : in_data;
`else
  assign w_byte = in_data;
`endif

  assign w_xfer     = in_valid && r_in_ready;
  assign w_last     = (r_elem_cnt == c_LAST_IDX);
  assign w_word_end = w_xfer && ((r_lane_idx == 2'd3) || w_last);

  // Current pack contents with the incoming byte merged into its lane; lanes
  // above lane_idx are still zero because the pack register is cleared per word.
  always_comb begin
    w_word = r_pack;
    w_word[{r_lane_idx, 3'b000} +: 8] = w_byte;
  end

  // Byte-enable mask covering lanes 0..lane_idx of the word being completed.
  always_comb begin
    w_mask = 4'b0000;
    case (r_lane_idx)
      2'd0: w_mask = 4'b0001;
      2'd1: w_mask = 4'b0011;
      2'd2: w_mask = 4'b0111;
      2'd3: w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  // Frame FSM, packing datapath and registered BRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lane_idx  <= 2'd0;
      r_elem_cnt  <= 21'd0;
      r_word_addr <= 32'd0;
      r_pack      <= 32'd0;
      r_in_ready  <= 1'b0;
      r_en        <= 1'b0;
      r_we        <= 4'b0000;
      r_din       <= 32'd0;
      r_addr      <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Write strobes and done are single-cycle unless re-armed below.
      r_en   <= 1'b0;
      r_we   <= 4'b0000;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_PACK;
            r_lane_idx  <= 2'd0;
            r_elem_cnt  <= 21'd0;
            r_word_addr <= BASE_ADDR;
            r_pack      <= 32'd0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_PACK: begin
          if (w_xfer) begin
            r_lane_idx <= r_lane_idx + 2'd1;
            r_elem_cnt <= r_elem_cnt + 21'd1;
            if (w_word_end) begin
              // Hand the word to the write register; packing of the next
              // word continues next cycle with no bubble.
              r_din       <= w_word;
              r_we        <= w_mask;
              r_en        <= 1'b1;
              r_addr      <= r_word_addr;
              r_word_addr <= r_word_addr + 32'd4;
              r_pack      <= 32'd0;
            end else begin
              r_pack <= w_word;
            end
            if (w_last) begin
              r_state    <= S_FLUSH;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // Final write is on the port this cycle.
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready          = r_in_ready;
  assign BRAM_PORTA_0_clk  = clk;
  assign BRAM_PORTA_0_addr = r_addr;
  assign BRAM_PORTA_0_din  = r_din;
  assign BRAM_PORTA_0_en   = r_en;
  assign BRAM_PORTA_0_we   = r_we;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

`default_nettype wire

// File: tb/tb_third_order_conv_bram_writer.sv
// ============================================================================
// Module   : tb_third_order_conv_bram_writer
// Brief    : Directed bench for third_order_conv_bram_writer using three
//            instances (FRAME_LEN 8, 6 and 1) sharing the data stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_third_order_conv_bram_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start6, start1;
  logic [7:0] in_data;
  logic       in_valid;

  logic        rdy8, bclk8, en8, busy8, done8;
  logic [31:0] addr8, din8;
  logic [3:0]  we8;
  logic        rdy6, bclk6, en6, busy6, done6;
  logic [31:0] addr6, din6;
  logic [3:0]  we6;
  logic        rdy1, bclk1, en1, busy1, done1;
  logic [31:0] addr1, din1;
  logic [3:0]  we1;

  int errors = 0;
  int checks = 0;
  int en8_cnt = 0, en6_cnt = 0, done6_cnt = 0, done8_cnt = 0;
  logic [7:0] bytes6 [6];

  always #5 clk = ~clk;

  third_order_conv_bram_writer #(.BASE_ADDR(32'h0000_0100), .FRAME_LEN(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy8), .BRAM_PORTA_0_clk(bclk8), .BRAM_PORTA_0_addr(addr8),
    .BRAM_PORTA_0_din(din8), .BRAM_PORTA_0_en(en8), .BRAM_PORTA_0_we(we8),
    .busy(busy8), .done(done8));

  third_order_conv_bram_writer #(.BASE_ADDR(32'h0000_0200), .FRAME_LEN(6)) u6 (
    .clk(clk), .rst(rst), .start(start6), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy6), .BRAM_PORTA_0_clk(bclk6), .BRAM_PORTA_0_addr(addr6),
    .BRAM_PORTA_0_din(din6), .BRAM_PORTA_0_en(en6), .BRAM_PORTA_0_we(we6),
    .busy(busy6), .done(done6));

  third_order_conv_bram_writer #(.BASE_ADDR(32'h0000_0300), .FRAME_LEN(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .BRAM_PORTA_0_clk(bclk1), .BRAM_PORTA_0_addr(addr1),
    .BRAM_PORTA_0_din(din1), .BRAM_PORTA_0_en(en1), .BRAM_PORTA_0_we(we1),
    .busy(busy1), .done(done1));

  // Pulse counters for write-enable and done strobes.
  always @(posedge clk) begin
    if (en8)   en8_cnt   <= en8_cnt + 1;
    if (en6)   en6_cnt   <= en6_cnt + 1;
    if (done8) done8_cnt <= done8_cnt + 1;
    if (done6) done6_cnt <= done6_cnt + 1;
  end

  // Expected effect of the optional clamp on one byte.
  function automatic logic [7:0] f(input logic [7:0] b);
`ifdef THIRD_ORDER_CONV_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic en, input logic [31:0] addr,
                       input logic [31:0] din, input logic [3:0] we,
                       input logic [31:0] e_addr, input logic [31:0] e_din,
                       input logic [3:0] e_we);
    chk({tag, ".en"}, {31'd0, en}, 32'd1);
    chk({tag, ".addr"}, addr, e_addr);
    chk({tag, ".din"}, din, e_din);
    chk({tag, ".we"}, {28'd0, we}, {28'd0, e_we});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start6 = 1'b0; start1 = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    bytes6[0] = 8'hAA; bytes6[1] = 8'hBB; bytes6[2] = 8'hCC;
    bytes6[3] = 8'hDD; bytes6[4] = 8'hEE; bytes6[5] = 8'hFF;
    repeat (3) tick();

    // Reset state
    chk("rst.en", {31'd0, en8}, 32'd0);
    chk("rst.we", {28'd0, we8}, 32'd0);
    chk("rst.din", din8, 32'd0);
    chk("rst.addr", addr8, 32'd0);
    chk("rst.busy", {31'd0, busy8}, 32'd0);
    chk("rst.done", {31'd0, done8}, 32'd0);
    chk("rst.ready", {31'd0, rdy8}, 32'd0);
    chk("rst.bclk", {31'd0, bclk8}, {31'd0, clk});

    // FRAME_LEN=8, bytes 01..08 streamed back to back
    rst = 1'b0; tick();
    start8 = 1'b1; tick();
    start8 = 1'b0;
    chk("f8.busy", {31'd0, busy8}, 32'd1);
    chk("f8.ready", {31'd0, rdy8}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      if (i == 4) chk_w("f8.w0", en8, addr8, din8, we8, 32'h100, 32'h0403_0201, 4'hF);
    end
    chk_w("f8.w1", en8, addr8, din8, we8, 32'h104, 32'h0807_0605, 4'hF);
    chk("f8.ready_drop", {31'd0, rdy8}, 32'd0);
    in_valid = 1'b0; tick();
    chk("f8.done", {31'd0, done8}, 32'd1);
    chk("f8.busy_done", {31'd0, busy8}, 32'd1);
    chk("f8.en_off", {31'd0, en8}, 32'd0);
    chk("f8.we_off", {28'd0, we8}, 32'd0);
    chk("f8.din_hold", din8, 32'h0807_0605);
    tick();
    chk("f8.done_off", {31'd0, done8}, 32'd0);
    chk("f8.busy_off", {31'd0, busy8}, 32'd0);
    chk("f8.en_count", en8_cnt, 2);
    chk("f8.done_count", done8_cnt, 1);

    // FRAME_LEN=6, valid toggling, start re-pulsed mid-frame
    start6 = 1'b1; tick();
    start6 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = bytes6[k];
      tick();
      if (k == 3)
        chk_w("f6.w0", en6, addr6, din6, we6, 32'h200,
              {f(8'hDD), f(8'hCC), f(8'hBB), f(8'hAA)}, 4'hF);
      in_valid = 1'b0; in_data = 8'h55;
      if (k == 1) start6 = 1'b1;
      tick();
      start6 = 1'b0;
      if (k == 3) chk("f6.en_gap", {31'd0, en6}, 32'd0);
    end
    chk("f6.ready_mid", {31'd0, rdy6}, 32'd1);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    chk_w("f6.w1", en6, addr6, din6, we6, 32'h204, {16'h0000, f(8'hFF), f(8'hEE)}, 4'b0011);
    in_valid = 1'b0; tick();
    chk("f6.done", {31'd0, done6}, 32'd1);
    repeat (4) tick();
    chk("f6.busy_off", {31'd0, busy6}, 32'd0);
    chk("f6.en_count", en6_cnt, 2);
    chk("f6.done_count", done6_cnt, 1);

    // FRAME_LEN=1, single byte
    start1 = 1'b1; tick();
    start1 = 1'b0;
    chk("f1.busy_pack", {31'd0, busy1}, 32'd1);
    chk("f1.ready", {31'd0, rdy1}, 32'd1);
    in_valid = 1'b1; in_data = 8'h7F; tick();
    in_valid = 1'b0;
    chk_w("f1.w0", en1, addr1, din1, we1, 32'h300, 32'h0000_007F, 4'b0001);
    chk("f1.busy_flush", {31'd0, busy1}, 32'd1);
    tick();
    chk("f1.done", {31'd0, done1}, 32'd1);
    chk("f1.busy_done", {31'd0, busy1}, 32'd1);
    tick();
    chk("f1.busy_off", {31'd0, busy1}, 32'd0);
    chk("f1.done_off", {31'd0, done1}, 32'd0);

    // Reset after three of four bytes abandons the word
    start8 = 1'b1; tick();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h11 * 8'(i + 1);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1; tick();
    chk("mr.en", {31'd0, en8}, 32'd0);
    chk("mr.we", {28'd0, we8}, 32'd0);
    chk("mr.din", din8, 32'd0);
    chk("mr.addr", addr8, 32'd0);
    chk("mr.busy", {31'd0, busy8}, 32'd0);
    chk("mr.ready", {31'd0, rdy8}, 32'd0);
    chk("mr.en_count", en8_cnt, 2);

    // New frame after reset: first word at BASE_ADDR, lane 0 first, clamp check
    rst = 1'b0; tick();
    start8 = 1'b1; tick();
    start8 = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h80; tick();
    in_data = 8'h01; tick();
    in_data = 8'hFF; tick();
    in_data = 8'h7F; tick();
`ifdef THIRD_ORDER_CONV_RELU_EN
    chk_w("rl.w0", en8, addr8, din8, we8, 32'h100, 32'h7F00_0100, 4'hF);
`else
    chk_w("rl.w0", en8, addr8, din8, we8, 32'h100, 32'h7FFF_0180, 4'hF);
`endif
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h20 + 8'(i); tick();
    end
    chk_w("rl.w1", en8, addr8, din8, we8, 32'h104, 32'h2322_2120, 4'hF);
    in_valid = 1'b0; tick();
    chk("rl.done", {31'd0, done8}, 32'd1);
    tick();
    chk("rl.done_count", done8_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
